mem_stage_ctrl: RTL

- MEM-stage consumer of the EX/MEM pipeline register in the 8-bit pipelined core; drives the data-memory request/acknowledge interface and loads the MEM/WB register.
- Executes loads and stores on a variable-latency data memory.
- Holds the upstream pipeline via stall_o while an access is outstanding.
- Guards each access with a timeout counter.

---
 rtl/mem_stage_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: consumes EX/MEM, runs loads/stores against a
// variable-latency request/acknowledge data memory, stalls upstream while an
// access is outstanding, guards each access with a timeout and loads MEM/WB.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_mem_i,
  input  logic       read_mem_i,
  input  logic       write_reg_i,
  input  logic [2:0] regD_i,
  input  logic [7:0] aluOut_i,
  input  logic [7:0] dataD_i,
  output logic       stall_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_wdata_o,
  input  logic       mem_ack_i,
  input  logic [7:0] mem_rdata_i,
  output logic       write_reg_o,
  output logic [2:0] regD_o,
  output logic [7:0] wbData_o,
  output logic       timeout_o,
  output logic       proto_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Last counter value before the timeout fires; guarded so TIMEOUT=0 does not underflow.
  localparam int               TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];
  localparam logic             TO_EN     = (TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             wr_lat_q, wr_lat_d;
  logic [2:0]       regd_lat_q, regd_lat_d;
  logic             write_reg_q, write_reg_d;
  logic [2:0]       regD_q, regD_d;
  logic [7:0]       wbData_q, wbData_d;
  logic             timeout_q, timeout_d;
  logic             proto_err_q, proto_err_d;

  logic memop;
  logic to_hit;

  assign memop  = read_mem_i | write_mem_i;
  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: ack beats a coincident timeout, DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memop) state_d = BUSY;
      BUSY:    if (mem_ack_i || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall upstream while accepting or waiting; released in DONE so the completed op retires.
  always_comb begin
    stall_o = (state_q == BUSY) || ((state_q == IDLE) && memop);
  end

  // Next values of the memory interface, timeout counter and MEM/WB register.
  always_comb begin
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_lat_d    = wr_lat_q;
    regd_lat_d  = regd_lat_q;
    write_reg_d = write_reg_q;
    regD_d      = regD_q;
    wbData_d    = wbData_q;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (memop) begin
          mem_req_d   = 1'b1;
          mem_we_d    = write_mem_i;
          mem_addr_d  = aluOut_i;
          mem_wdata_d = dataD_i;
          // Stores never write back a register.
          wr_lat_d    = write_reg_i & ~write_mem_i;
          regd_lat_d  = regD_i;
          write_reg_d = 1'b0;
          cnt_d       = '0;
          if (read_mem_i && write_mem_i) proto_err_d = 1'b1;
        end else begin
          write_reg_d = write_reg_i;
          regD_d      = regD_i;
          wbData_d    = aluOut_i;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            write_reg_d = wr_lat_q;
            regD_d      = regd_lat_q;
            wbData_d    = mem_rdata_i;
          end else begin
            write_reg_d = 1'b0;
          end
        end else begin
          write_reg_d = 1'b0;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (to_hit) begin
            mem_req_d = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end
      DONE:    write_reg_d = 1'b0;
      default: write_reg_d = 1'b0;
    endcase
  end

  // Datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_lat_q    <= 1'b0;
      regd_lat_q  <= '0;
      write_reg_q <= 1'b0;
      regD_q      <= '0;
      wbData_q    <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_lat_q    <= wr_lat_d;
      regd_lat_q  <= regd_lat_d;
      write_reg_q <= write_reg_d;
      regD_q      <= regD_d;
      wbData_q    <= wbData_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign write_reg_o = write_reg_q;
  assign regD_o      = regD_q;
  assign wbData_o    = wbData_q;
  assign timeout_o   = timeout_q;
  assign proto_err_o = proto_err_q;

endmodule
